// File: rtl/gpu_clk_pkg.sv
// Shared clocking/reset types and default cycle counts
// for the clk_core (100 MHz) domain.
package gpu_clk_pkg;

   localparam int CORE_CLK_HZ = 100_000_000;

   localparam int DEF_SYNC_STAGES          = 2;
   localparam int DEF_LOCK_FILTER_CYCLES   = 1024;
   // 200 us SDRAM power-up wait
   localparam int DEF_SDRAM_PWRUP_CYCLES   = CORE_CLK_HZ / 5_000;
   // 1 ms budget for the controller init sequence
   localparam int DEF_INIT_TIMEOUT_CYCLES  = CORE_CLK_HZ / 1_000;
   localparam int DEF_DISPLAY_DELAY_CYCLES = 16;

   localparam logic [7:0] LOSS_CNT_MAX = 8'hFF;

   typedef enum logic [2:0] {
      WAIT_LOCK  = 3'd0,
      PWRUP_WAIT = 3'd1,
      SDRAM_INIT = 3'd2,
      CORE_REL   = 3'd3,
      RUN        = 3'd4
   } seq_state_t;

   function automatic int max_of4(int a, int b, int c, int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   // bits needed to hold 0 .. max_val-1
   function automatic int timer_width(int max_val);
      return (max_val <= 2) ? 1 : $clog2(max_val);
   endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Lock/init inputs and reset/diagnostic outputs of the
// reset sequencer, grouped for the clock/reset subsystem.
interface reset_sequencer_if;

   logic       pll_locked;
   logic       sdram_init_done;
   logic       rst_sdram_ctrl;
   logic       rst_core;
   logic       rst_display;
   logic       sys_ready;
   logic [7:0] lock_loss_count;
   logic       init_timeout_flag;
   logic [2:0] seq_state;

   modport master (
      input  pll_locked,
      input  sdram_init_done,
      output rst_sdram_ctrl,
      output rst_core,
      output rst_display,
      output sys_ready,
      output lock_loss_count,
      output init_timeout_flag,
      output seq_state
   );

   modport slave (
      output pll_locked,
      output sdram_init_done,
      input  rst_sdram_ctrl,
      input  rst_core,
      input  rst_display,
      input  sys_ready,
      input  lock_loss_count,
      input  init_timeout_flag,
      input  seq_state
   );

endinterface

// File: rtl/sync_ff.sv
// N-flop single-bit synchronizer for asynchronous level
// inputs; cleared by the synchronous reset.
module sync_ff #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [N-1:0] chain;

   // shift the async level through the flop chain
   always_ff @(posedge clk) begin
      if (rst) chain <= '0;
      else     chain <= {chain[N-2:0], d};
   end

   assign q = chain[N-1];

endmodule

// File: rtl/reset_sequencer.sv
// Power-up / lock-loss reset sequencer: SDRAM ctrl, then
// GPU core, then display path, with lock-loss diagnostics.
module reset_sequencer
   import gpu_clk_pkg::*;
#(
   parameter int SYNC_STAGES          = DEF_SYNC_STAGES,
   parameter int LOCK_FILTER_CYCLES   = DEF_LOCK_FILTER_CYCLES,
   parameter int SDRAM_PWRUP_CYCLES   = DEF_SDRAM_PWRUP_CYCLES,
   parameter int INIT_TIMEOUT_CYCLES  = DEF_INIT_TIMEOUT_CYCLES,
   parameter int DISPLAY_DELAY_CYCLES = DEF_DISPLAY_DELAY_CYCLES
) (
   input logic               clk_core,
   input logic               rst,
   reset_sequencer_if.master seq
);

   localparam int TMAX = max_of4(LOCK_FILTER_CYCLES,
                                 SDRAM_PWRUP_CYCLES,
                                 INIT_TIMEOUT_CYCLES,
                                 DISPLAY_DELAY_CYCLES);
   localparam int TW = timer_width(TMAX);

   localparam logic [TW-1:0] LOCK_LAST  = TW'(LOCK_FILTER_CYCLES - 1);
   localparam logic [TW-1:0] PWRUP_LAST = TW'(SDRAM_PWRUP_CYCLES - 1);
   localparam logic [TW-1:0] INIT_LAST  = TW'(INIT_TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] DISP_LAST  = TW'(DISPLAY_DELAY_CYCLES - 1);

   logic          lock_s;
   seq_state_t    state;
   seq_state_t    state_nxt;
   logic [TW-1:0] timer;
   logic [TW-1:0] timer_nxt;
   logic [7:0]    loss_nxt;
   logic          flag_nxt;

   sync_ff #(.N(SYNC_STAGES)) u_lock_sync (
      .clk (clk_core),
      .rst (rst),
      .d   (seq.pll_locked),
      .q   (lock_s)
   );

   // next state, shared timer and diagnostics; lock loss
   // outranks done/timeout, which outrank timer expiry
   always_comb begin
      state_nxt = state;
      timer_nxt = timer + TW'(1);
      loss_nxt  = seq.lock_loss_count;
      flag_nxt  = seq.init_timeout_flag;
      if (state != WAIT_LOCK && !lock_s) begin
         state_nxt = WAIT_LOCK;
         timer_nxt = '0;
         if (seq.lock_loss_count != LOSS_CNT_MAX)
            loss_nxt = seq.lock_loss_count + 8'd1;
      end else begin
         unique case (state)
            WAIT_LOCK: begin
               if (!lock_s) begin
                  timer_nxt = '0;
               end else if (timer == LOCK_LAST) begin
                  state_nxt = PWRUP_WAIT;
                  timer_nxt = '0;
               end
            end
            PWRUP_WAIT: begin
               if (timer == PWRUP_LAST) begin
                  state_nxt = SDRAM_INIT;
                  timer_nxt = '0;
               end
            end
            SDRAM_INIT: begin
               if (seq.sdram_init_done) begin
                  state_nxt = CORE_REL;
                  timer_nxt = '0;
               end else if (timer == INIT_LAST) begin
                  state_nxt = PWRUP_WAIT;
                  timer_nxt = '0;
                  flag_nxt  = 1'b1;
               end
            end
            CORE_REL: begin
               if (timer == DISP_LAST) begin
                  state_nxt = RUN;
                  timer_nxt = '0;
               end
            end
            RUN: begin
               timer_nxt = '0;
            end
            default: begin
               state_nxt = WAIT_LOCK;
               timer_nxt = '0;
            end
         endcase
      end
   end

   // state, timer and all outputs registered from next state
   always_ff @(posedge clk_core) begin
      if (rst) begin
         state                 <= WAIT_LOCK;
         timer                 <= '0;
         seq.rst_sdram_ctrl    <= 1'b1;
         seq.rst_core          <= 1'b1;
         seq.rst_display       <= 1'b1;
         seq.sys_ready         <= 1'b0;
         seq.lock_loss_count   <= '0;
         seq.init_timeout_flag <= 1'b0;
         seq.seq_state         <= WAIT_LOCK;
      end else begin
         state                 <= state_nxt;
         timer                 <= timer_nxt;
         seq.rst_sdram_ctrl    <= (state_nxt == WAIT_LOCK) ||
                                  (state_nxt == PWRUP_WAIT);
         seq.rst_core          <= (state_nxt != CORE_REL) &&
                                  (state_nxt != RUN);
         seq.rst_display       <= (state_nxt != RUN);
         seq.sys_ready         <= (state_nxt == RUN);
         seq.lock_loss_count   <= loss_nxt;
         seq.init_timeout_flag <= flag_nxt;
         seq.seq_state         <= state_nxt;
      end
   end

   // downstream blocks must never leave reset before upstream
   a_core_after_sdram : assert property (
      @(posedge clk_core) disable iff (rst)
      !seq.rst_core |-> !seq.rst_sdram_ctrl);

   a_disp_after_core : assert property (
      @(posedge clk_core) disable iff (rst)
      !seq.rst_display |-> !seq.rst_core);

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized self-checking bench for reset_sequencer against
// a phase/age reference model (params 2/8/20/50/4).
module tb_reset_sequencer;

   localparam int SS = 2;
   localparam int LF = 8;
   localparam int PW = 20;
   localparam int IT = 50;
   localparam int DD = 4;
   localparam logic [15:0] RST_VEC = 16'hE000;

   logic clk_core = 1'b0;
   logic rst = 1'b1;

   reset_sequencer_if bus();

   reset_sequencer #(
      .SYNC_STAGES          (SS),
      .LOCK_FILTER_CYCLES   (LF),
      .SDRAM_PWRUP_CYCLES   (PW),
      .INIT_TIMEOUT_CYCLES  (IT),
      .DISPLAY_DELAY_CYCLES (DD)
   ) dut (
      .clk_core (clk_core),
      .rst      (rst),
      .seq      (bus)
   );

   always #5 clk_core = ~clk_core;

   int checks = 0;
   int errors = 0;

   // reference model: phase 0..4, cycles spent in phase,
   // consecutive synchronized lock samples
   int m_phase = 0;
   int m_age = 0;
   int m_run = 0;
   int m_cnt = 0;
   bit m_flag = 1'b0;
   bit m_sync [SS];

   always @(posedge clk_core) begin : model
      bit ls;
      if (rst) begin
         m_phase = 0; m_age = 0; m_run = 0;
         m_cnt = 0; m_flag = 1'b0;
         foreach (m_sync[i]) m_sync[i] = 1'b0;
      end else begin
         ls = m_sync[SS-1];
         for (int i = SS-1; i > 0; i--) m_sync[i] = m_sync[i-1];
         m_sync[0] = bus.pll_locked;
         if (m_phase == 0) begin
            if (ls) begin
               m_run++;
               if (m_run == LF) begin m_phase = 1; m_age = 0; end
            end else m_run = 0;
         end else if (!ls) begin
            m_phase = 0; m_run = 0;
            if (m_cnt < 255) m_cnt++;
         end else begin
            case (m_phase)
               1: begin
                  m_age++;
                  if (m_age == PW) begin m_phase = 2; m_age = 0; end
               end
               2: begin
                  if (bus.sdram_init_done) begin
                     m_phase = 3; m_age = 0;
                  end else begin
                     m_age++;
                     if (m_age == IT) begin
                        m_flag = 1'b1; m_phase = 1; m_age = 0;
                     end
                  end
               end
               3: begin
                  m_age++;
                  if (m_age == DD) m_phase = 4;
               end
               default: ;
            endcase
         end
      end
   end

   logic [15:0] exp_vec;
   logic [15:0] dut_vec;
   logic [7:0]  m_cnt8;
   logic [2:0]  m_ph3;

   assign m_cnt8 = m_cnt[7:0];
   assign m_ph3  = m_phase[2:0];
   assign exp_vec = {m_phase <= 1, m_phase <= 2, m_phase != 4,
                     m_phase == 4, m_flag, m_cnt8, m_ph3};
   assign dut_vec = {bus.rst_sdram_ctrl, bus.rst_core,
                     bus.rst_display, bus.sys_ready,
                     bus.init_timeout_flag, bus.lock_loss_count,
                     bus.seq_state};

   task automatic tick();
      @(posedge clk_core);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.pll_locked = 1'b0;
      bus.sdram_init_done = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
   endtask

   // drive lock and done until RUN; ok=0 if budget expires
   task automatic go_run(output bit ok);
      bus.pll_locked = 1'b1;
      bus.sdram_init_done = 1'b1;
      for (int k = 0; k < 100 && !bus.sys_ready; k++) tick();
      ok = bus.sys_ready;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.pll_locked = 1'b1;
      bus.sdram_init_done = 1'b1;
      repeat (5) tick();
      checks++;
      if (dut_vec !== RST_VEC) begin
         errors++;
         $display("FAIL reset_hold: got %h expected %h", dut_vec, RST_VEC);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (dut_vec !== RST_VEC) begin
         errors++;
         $display("FAIL reset_after: got %h expected %h", dut_vec, RST_VEC);
      end
   endtask

   task automatic test_powerup();
      int k_pw, k_sd, k_core, k_disp;
      k_pw = -1; k_sd = -1; k_core = -1; k_disp = -1;
      rst = 1'b1;
      bus.pll_locked = 1'b0;
      bus.sdram_init_done = 1'b0;
      repeat (5) tick();
      rst = 1'b0;
      repeat (5) tick();
      bus.pll_locked = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         bus.sdram_init_done = (k >= 45);
         tick();
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++;
            $display("FAIL powerup_k%0d: got %h expected %h", k, dut_vec, exp_vec);
         end
         if (k_pw < 0 && bus.seq_state == 3'd1) k_pw = k;
         if (k_sd < 0 && !bus.rst_sdram_ctrl) k_sd = k;
         if (k_core < 0 && !bus.rst_core) k_core = k;
         if (k_disp < 0 && !bus.rst_display && bus.sys_ready) k_disp = k;
      end
      checks++;
      if (k_pw != 10) begin
         errors++;
         $display("FAIL powerup_pwrup_entry: got %0d expected 10", k_pw);
      end
      checks++;
      if (k_sd != 30) begin
         errors++;
         $display("FAIL powerup_sdram_rel: got %0d expected 30", k_sd);
      end
      checks++;
      if (k_core != 45) begin
         errors++;
         $display("FAIL powerup_core_rel: got %0d expected 45", k_core);
      end
      checks++;
      if (k_disp != 49) begin
         errors++;
         $display("FAIL powerup_disp_rel: got %0d expected 49", k_disp);
      end
   endtask

   task automatic test_glitch();
      int k_pw;
      k_pw = -1;
      do_reset();
      for (int k = 1; k <= 30; k++) begin
         bus.pll_locked = (k != 6);
         bus.sdram_init_done = 1'($urandom_range(0, 1));
         tick();
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++;
            $display("FAIL glitch_k%0d: got %h expected %h", k, dut_vec, exp_vec);
         end
         if (k_pw < 0 && bus.seq_state == 3'd1) k_pw = k;
      end
      checks++;
      if (k_pw != 16) begin
         errors++;
         $display("FAIL glitch_filter_exit: got %0d expected 16", k_pw);
      end
      checks++;
      if (bus.lock_loss_count !== 8'd0) begin
         errors++;
         $display("FAIL glitch_count: got %0d expected 0", bus.lock_loss_count);
      end
   endtask

   task automatic test_lock_loss();
      bit ok;
      int k_rst;
      k_rst = -1;
      do_reset();
      go_run(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL lockloss_reach_run: got 0 expected 1");
      end
      for (int k = 1; k <= 6; k++) begin
         bus.pll_locked = (k != 1);
         tick();
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++;
            $display("FAIL lockloss_k%0d: got %h expected %h", k, dut_vec, exp_vec);
         end
         if (k_rst < 0 && bus.rst_sdram_ctrl && bus.rst_core &&
             bus.rst_display && !bus.sys_ready) k_rst = k;
      end
      checks++;
      if (k_rst != 3) begin
         errors++;
         $display("FAIL lockloss_latency: got %0d expected 3", k_rst);
      end
      checks++;
      if (bus.lock_loss_count !== 8'd1) begin
         errors++;
         $display("FAIL lockloss_count: got %0d expected 1", bus.lock_loss_count);
      end
      for (int k = 0; k < 100 && !bus.sys_ready; k++) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++;
            $display("FAIL relock_k%0d: got %h expected %h", k, dut_vec, exp_vec);
         end
      end
      checks++;
      if (!bus.sys_ready) begin
         errors++;
         $display("FAIL relock_run: got 0 expected 1");
      end
   endtask

   task automatic test_timeout();
      int k, k_init, k_to;
      k_init = -1; k_to = -1;
      do_reset();
      bus.pll_locked = 1'b1;
      bus.sdram_init_done = 1'b0;
      for (k = 1; k <= 200 && k_to < 0; k++) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++;
            $display("FAIL timeout_k%0d: got %h expected %h", k, dut_vec, exp_vec);
         end
         if (k_init < 0 && bus.seq_state == 3'd2) k_init = k;
         if (k_to < 0 && bus.init_timeout_flag) k_to = k;
      end
      checks++;
      if (k_init < 0 || k_to - k_init != IT) begin
         errors++;
         $display("FAIL timeout_delay: got %0d expected %0d", k_to - k_init, IT);
      end
      checks++;
      if (bus.seq_state !== 3'd1 || bus.rst_sdram_ctrl !== 1'b1) begin
         errors++;
         $display("FAIL timeout_retry: got st=%0d rs=%b expected st=1 rs=1", bus.seq_state, bus.rst_sdram_ctrl);
      end
      bus.sdram_init_done = 1'b1;
      for (k = 0; k < 60 && !bus.sys_ready; k++) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++;
            $display("FAIL retry_k%0d: got %h expected %h", k, dut_vec, exp_vec);
         end
      end
      checks++;
      if (!bus.sys_ready || bus.init_timeout_flag !== 1'b1) begin
         errors++;
         $display("FAIL retry_run: got rdy=%b flag=%b expected 1 1", bus.sys_ready, bus.init_timeout_flag);
      end
   endtask

   task automatic test_simultaneous();
      bit ok;
      int k;
      do_reset();
      bus.pll_locked = 1'b1;
      bus.sdram_init_done = 1'b0;
      for (k = 0; k < 100 && bus.seq_state != 3'd2; k++) tick();
      checks++;
      if (bus.seq_state != 3'd2) begin
         errors++;
         $display("FAIL simul_reach_init: got %0d expected 2", bus.seq_state);
      end
      for (k = 1; k <= IT; k++) begin
         bus.pll_locked = (k != IT - SS);
         tick();
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++;
            $display("FAIL simul_k%0d: got %h expected %h", k, dut_vec, exp_vec);
         end
      end
      checks++;
      if (bus.seq_state !== 3'd0 || bus.init_timeout_flag !== 1'b0 ||
          bus.lock_loss_count !== 8'd1) begin
         errors++;
         $display("FAIL simul_loss_vs_timeout: got st=%0d flag=%b cnt=%0d expected 0 0 1", bus.seq_state, bus.init_timeout_flag, bus.lock_loss_count);
      end
      go_run(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL simul_reach_run: got 0 expected 1");
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (dut_vec !== RST_VEC) begin
         errors++;
         $display("FAIL simul_rst_in_run: got %h expected %h", dut_vec, RST_VEC);
      end
   endtask

   task automatic test_saturation();
      int k;
      bit hit;
      do_reset();
      bus.sdram_init_done = 1'b1;
      for (int i = 0; i < 300; i++) begin
         bus.pll_locked = 1'b1;
         hit = 1'b0;
         for (k = 0; k < 100 && !hit; k++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec) begin
               errors++;
               if (errors < 20)
                  $display("FAIL sat_i%0d: got %h expected %h", i, dut_vec, exp_vec);
            end
            checks++;
            if ((!bus.rst_core && bus.rst_sdram_ctrl) ||
                (!bus.rst_display && bus.rst_core)) begin
               errors++;
               if (errors < 20)
                  $display("FAIL sat_order_i%0d: got %h expected ordered", i, dut_vec);
            end
            hit = (i % 2 == 0) ? bus.sys_ready : (bus.seq_state == 3'd3);
         end
         checks++;
         if (!hit) begin
            errors++;
            $display("FAIL sat_wait_i%0d: got timeout expected target", i);
         end
         bus.pll_locked = 1'b0;
         tick();
         bus.pll_locked = 1'b1;
         for (k = 0; k < 10 && bus.seq_state != 3'd0; k++) tick();
         checks++;
         if (bus.seq_state != 3'd0) begin
            errors++;
            $display("FAIL sat_drop_i%0d: got %0d expected 0", i, bus.seq_state);
         end
      end
      checks++;
      if (bus.lock_loss_count !== 8'd255 || m_cnt != 255) begin
         errors++;
         $display("FAIL sat_count: got %0d expected 255", bus.lock_loss_count);
      end
   endtask

   initial begin
      bus.pll_locked = 1'b0;
      bus.sdram_init_done = 1'b0;
      test_reset();
      test_powerup();
      test_glitch();
      test_lock_loss();
      test_timeout();
      test_simultaneous();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Consumes the PLL lock indicator and builds the system's power-up and lock-loss reset sequence in the clk_core (100 MHz) domain.
- Orders the resets: first the SDRAM controller (after the SDRAM power-up wait), then the GPU core, then the display/TMDS path.
- Re-runs the sequence whenever PLL lock drops.
- Also reports lock-loss and SDRAM-init-timeout diagnostics to the register file.

Parameters:
- SYNC_STAGES, 2, flops in the pll_locked synchronizer (min 2).
- LOCK_FILTER_CYCLES, 1024, consecutive synchronized-high lock samples required before sequencing starts.
- SDRAM_PWRUP_CYCLES, 20000, cycles rst_sdram_ctrl stays asserted after lock (200 us at 100 MHz).
- INIT_TIMEOUT_CYCLES, 100000, max cycles to wait for sdram_init_done.
- DISPLAY_DELAY_CYCLES, 16, cycles between rst_core release and rst_display release.

Ports:
- clk_core, in, 1: 100 MHz unified core clock; the only clock.
- rst, in, 1: synchronous, active-high master reset.
- pll_locked, in, 1: PLL lock; asynchronous, synchronized internally.
- sdram_init_done, in, 1: SDRAM controller init-complete level; clk_core domain.
- rst_sdram_ctrl, out, 1: active-high sync reset to the SDRAM controller.
- rst_core, out, 1: active-high sync reset to the GPU core.
- rst_display, out, 1: active-high reset request to the display/TMDS path; the pixel domain re-synchronizes it.
- sys_ready, out, 1: high only in RUN.
- lock_loss_count, out, 8: saturating count of lock losses.
- init_timeout_flag, out, 1: sticky; set on any SDRAM init timeout.
- seq_state, out, 3: current state encoding, for debug.

Behaviour:
- Interface: single clock clk_core. Reset rst is synchronous and active-high.
- Registered outputs: all outputs are registered.
  - Values while rst=1 and on the cycle after: rst_sdram_ctrl=1, rst_core=1, rst_display=1, sys_ready=0, lock_loss_count=0, init_timeout_flag=0, seq_state=WAIT_LOCK.
  - rst also clears the synchronizer and all counters.
- Synchronizer: pll_locked passes through SYNC_STAGES flops to produce lock_s. Each cycle, a single timer (width sized to the largest parameter) either counts or clears per state.
- WAIT_LOCK: all three resets asserted.
  - Timer increments while lock_s=1 and clears when lock_s=0.
  - When the timer reaches LOCK_FILTER_CYCLES-1 with lock_s=1, go to PWRUP_WAIT and clear the timer.
- PWRUP_WAIT: all resets asserted. After exactly SDRAM_PWRUP_CYCLES cycles in this state, go to SDRAM_INIT.
- SDRAM_INIT: rst_sdram_ctrl=0 from the first cycle of the state; rst_core and rst_display stay 1.
  - If sdram_init_done=1, go to CORE_REL.
  - If the timer reaches INIT_TIMEOUT_CYCLES-1 without done: set init_timeout_flag and return to PWRUP_WAIT (rst_sdram_ctrl reasserts). This retries indefinitely.
- CORE_REL: rst_core=0 on entry. After DISPLAY_DELAY_CYCLES cycles, go to RUN.
- RUN: rst_display=0, sys_ready=1.
  - sdram_init_done falling in RUN is ignored; it is the controller's own concern.
- Lock loss (lock_s=0 in PWRUP_WAIT, SDRAM_INIT, CORE_REL or RUN):
  - Next state is WAIT_LOCK.
  - All resets reassert and sys_ready drops on the same edge.
  - lock_loss_count increments, saturating at 255.
  - Latency from pll_locked falling to the resets asserting is SYNC_STAGES+1 cycles.
  - Lock drops inside WAIT_LOCK are filter glitches and are not counted.
- Priority: rst > lock loss > timeout/done > timer expiry.
  - Lock loss and timeout in the same cycle: lock loss wins and init_timeout_flag is not set.
  - Lock loss and sdram_init_done in the same cycle: lock loss wins.
- Reset ordering invariant, at all times:
  - rst_core=0 implies rst_sdram_ctrl=0.
  - rst_display=0 implies rst_core=0.
  - Violation is an assertion failure.

Decomposition:
- Shared package gpu_clk_pkg holds:
  - The state enum seq_state_t: WAIT_LOCK=0, PWRUP_WAIT=1, SDRAM_INIT=2, CORE_REL=3, RUN=4.
  - Default cycle constants derived from CORE_CLK_HZ=100_000_000.
- One natural sub-module: sync_ff (parameterized N-flop bit synchronizer), reused for other async inputs.
- Timer and FSM stay in reset_sequencer.

Test Plan (params 2/8/20/50/4):
1. Power-up: rst high 5 cycles, then low; pll_locked=1 at cycle 10; sdram_init_done=1 at 15 cycles after SDRAM_INIT entry.
   - PWRUP_WAIT entered after 2+8 cycles.
   - rst_sdram_ctrl falls 20 cycles later.
   - rst_core falls the cycle after done.
   - rst_display falls and sys_ready rises 4 cycles after that.
2. Lock glitch filter: pll_locked high 5 cycles, low 1, then high.
   - Stays in WAIT_LOCK until 8 consecutive lock_s highs.
   - lock_loss_count stays 0.
3. Lock loss in RUN: drop pll_locked for 1 cycle.
   - All resets high and sys_ready=0 within 3 cycles.
   - lock_loss_count=1.
   - Full sequence replays on relock.
4. Init timeout: hold sdram_init_done=0.
   - After 50 cycles in SDRAM_INIT: init_timeout_flag=1, back in PWRUP_WAIT with rst_sdram_ctrl=1.
   - Asserting done on the retry reaches RUN; the flag stays 1.
5. Simultaneous events:
   - Lock loss on the same cycle as timeout expiry: WAIT_LOCK, flag=0, count+1.
   - rst during RUN: all outputs return to reset values the next cycle.
6. Saturation: 300 lock-loss events from RUN/CORE_REL. lock_loss_count holds 255; ordering assertions never fire.
